max7219_spi_tx: RTL

Serial transmitter for the 8x8 LED matrix driver (MAX7219-class). It accepts a 128-bit display frame made of eight 16-bit {address byte, data byte} words, the same format the matrix pattern generator produces on led_on. It shifts the frame out MSB-first over a 3-wire SPI-style link (sclk, cs_n, din) and raises cs_n after each word so the device latches it. It sits between the pattern generator and the board pins, and a top-level frame refresher drives its start input.

---
 rtl/max7219_spi_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/max7219_spi_tx.sv
// max7219_spi_tx: shifts eight 16-bit MAX7219 words out over sclk/cs_n/din, MSB first.
// Define MAX7219_INIT_EN to send a five-word device init sequence after reset.
module max7219_spi_tx #(
   parameter int         CLK_DIV   = 4,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] frame,
   output logic         busy,
   output logic         done,
   output logic         sclk,
   output logic         cs_n,
   output logic         din
);
   localparam int CW = $clog2(2*CLK_DIV+1);
   localparam logic [CW-1:0] PH_END  = CW'(CLK_DIV-1);
   localparam logic [CW-1:0] GAP_END = CW'(2*CLK_DIV-1);
`ifdef MAX7219_INIT_EN
   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP, INIT} state_t;
   localparam state_t RST_STATE = INIT;
   localparam logic [127:0] INIT_WORDS = {16'h0C01, 16'h0B07, 16'h0900, 12'h0A0, INTENSITY, 16'h0F00, 48'h0};
   logic init_seq;
`else
   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
   localparam state_t RST_STATE = IDLE;
   logic init_seq;
   assign init_seq = 1'b0;
`endif
   state_t         state;
   logic [127:0]   sr;
   logic [CW-1:0]  cnt;
   logic [3:0]     bit_cnt;
   logic [2:0]     word_cnt;
   logic           last_word;
   assign last_word = word_cnt == (init_seq ? 3'd4 : 3'd7);
   // din always leads from sr[127]; each shift exposes the next bit at the same edge sclk drops
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= RST_STATE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sclk     <= 1'b0;
         cs_n     <= 1'b1;
         din      <= 1'b0;
         sr       <= '0;
         cnt      <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
`ifdef MAX7219_INIT_EN
         init_seq <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sr       <= frame;
               din      <= frame[127];
               state    <= SHIFT_LO;
               busy     <= 1'b1;
               cs_n     <= 1'b0;
               cnt      <= '0;
               bit_cnt  <= 4'd15;
               word_cnt <= '0;
            end
`ifdef MAX7219_INIT_EN
            INIT: begin
               sr       <= INIT_WORDS;
               din      <= INIT_WORDS[127];
               init_seq <= 1'b1;
               state    <= SHIFT_LO;
               busy     <= 1'b1;
               cs_n     <= 1'b0;
               cnt      <= '0;
               bit_cnt  <= 4'd15;
               word_cnt <= '0;
            end
`endif
            SHIFT_LO: if (cnt == PH_END) begin
               cnt   <= '0;
               sclk  <= 1'b1;
               state <= SHIFT_HI;
            end else cnt <= cnt + 1'b1;
            SHIFT_HI: if (cnt == PH_END) begin
               cnt  <= '0;
               sclk <= 1'b0;
               if (bit_cnt == 4'd0) state <= HOLD;
               else begin
                  state   <= SHIFT_LO;
                  bit_cnt <= bit_cnt - 1'b1;
                  sr      <= {sr[126:0], 1'b0};
                  din     <= sr[126];
               end
            end else cnt <= cnt + 1'b1;
            HOLD: if (cnt == PH_END) begin
               cnt   <= '0;
               cs_n  <= 1'b1;
               din   <= 1'b0;
               state <= GAP;
            end else cnt <= cnt + 1'b1;
            GAP: if (cnt == GAP_END) begin
               cnt <= '0;
               if (last_word) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= ~init_seq;
`ifdef MAX7219_INIT_EN
                  init_seq <= 1'b0;
`endif
               end else begin
                  state    <= SHIFT_LO;
                  word_cnt <= word_cnt + 1'b1;
                  bit_cnt  <= 4'd15;
                  cs_n     <= 1'b0;
                  sr       <= {sr[126:0], 1'b0};
                  din      <= sr[126];
               end
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule
